// File: rtl/serial_sub_16bit_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_16bit_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
// Ports:
//   x    - minuend bit
//   y    - subtrahend bit
//   bin  - borrow-in
//   d    - difference bit
//   bout - borrow-out
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // Borrow when y exceeds x, or when x equals y and a borrow is pending.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub_16bit.sv
// Bit-serial subtractor. On an accepted start, captures a, b and bin, then
// processes one bit per clock, LSB first, through a single full subtractor.
// After WIDTH bit cycles and one DONE cycle, diff/bout are updated and done
// pulses for one cycle. All outputs are registered.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   start - begin a subtraction (sampled only in IDLE)
//   a, b  - minuend and subtrahend (WIDTH bits)
//   bin   - borrow-in
//   diff  - a - b - bin modulo 2^WIDTH (held until the next completion)
//   bout  - borrow-out, 1 when a < b + bin
//   busy  - high while an operation is in RUN or DONE
//   done  - one-cycle completion pulse
module serial_sub_16bit
  import serial_sub_16bit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_br;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
  logic               r_busy;
  logic               r_done;

  logic               w_d;
  logic               w_bo;

  // Bit slice operates on the current LSBs of the operand shift registers.
  full_subtractor u_fs (
    .x   (r_a[0]),
    .y   (r_b[0]),
    .bin (r_br),
    .d   (w_d),
    .bout(w_bo)
  );

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end

        RUN: begin
          // Shift operands right, shift the result bit in at the MSB so the
          // first (LSB) result bit lands at bit 0 after WIDTH cycles.
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_bo;
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= DONE;
          end
        end

        DONE: begin
          r_diff  <= r_res;
          r_bout  <= r_br;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_serial_sub_16bit.sv
// Self-checking bench for serial_sub_16bit: an arithmetic reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_serial_sub_16bit;

  localparam int unsigned W  = 16;
  localparam int unsigned W1 = W + 1;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;

  int n_total = 0;
  int n_pass  = 0;
  int n_done  = 0;

  serial_sub_16bit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .diff (diff),
    .bout (bout),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
  endtask

  // Reference model: a pending result computed with plain wide arithmetic,
  // published WIDTH+1 edges after the accepting edge.
  bit           m_active = 1'b0;
  int           m_edges  = 0;
  logic [W-1:0] m_pdiff  = '0;
  logic         m_pbout  = 1'b0;
  logic [W-1:0] m_diff   = '0;
  logic         m_bout   = 1'b0;
  logic         m_busy   = 1'b0;
  logic         m_done   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_edges  = 0;
      m_diff   = '0;
      m_bout   = 1'b0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_edges++;
        if (m_edges == W + 1) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_diff   = m_pdiff;
          m_bout   = m_pbout;
        end
      end else if (start) begin
        m_active = 1'b1;
        m_edges  = 0;
        {m_pbout, m_pdiff} = {1'b0, a} - {1'b0, b} - W1'(bin);
      end
      m_busy = m_active;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("diff",  32'(diff), 32'(m_diff));
    chk("bout",  32'(bout), 32'(m_bout));
    chk("busy",  32'(busy), 32'(m_busy));
    chk("done",  32'(done), 32'(m_done));
    if (done === 1'b1) n_done++;
  end

  // Called at a negedge. Issues start, disturbs the inputs after capture,
  // waits (bounded) for done and checks latency and literal results.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tbin, input bit hold,
                        input logic [W-1:0] xd, input logic xb, input string tag);
    int k;
    bit seen;
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      a = '0; b = '0;
    end else begin
      a = ~ta; b = ta ^ tb_v; bin = ~tbin;
      start = 1'b0;
    end
    k = 0;
    seen = 1'b0;
    while (k < 40 && !seen) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) seen = 1'b1;
      else if (k >= int'(W)) start = 1'b0;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(k), 32'(W + 1));
    chk({tag, "_diff"},    32'(diff), 32'(xd));
    chk({tag, "_bout"},    32'(bout), 32'(xb));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t vecs[4] = '{
    '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1},
    '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0},
    '{16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0}
  };

  int nd0;

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_diff", 32'(diff), 32'h0);
    chk("rst_bout", 32'(bout), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;

    // Start on the very first edge after reset release.
    run_op(16'h1234, 16'h0234, 1'b0, 1'b0, 16'h1000, 1'b0, "basic");
    @(negedge clk);
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, "underflow");
    @(negedge clk);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, "borrow_chain");
    repeat (3) @(negedge clk);

    // Start held high through RUN, then a back-to-back start in the done cycle.
    #1 nd0 = n_done;
    run_op(16'h00FF, 16'h000F, 1'b0, 1'b1, 16'h00F0, 1'b0, "held_start");
    run_op(16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0002, 1'b0, "back_to_back");
    #1 chk("dones_per_two_starts", 32'(n_done - nd0), 32'd2);
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, vecs[i].d, vecs[i].bo, "table");
      @(negedge clk);
    end

    // Reset in the middle of RUN aborts without a done pulse.
    a = 16'hAAAA; b = 16'h1111; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_diff", 32'(diff), 32'h0);
    chk("mid_rst_bout", 32'(bout), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    nd0 = n_done;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    #1 chk("no_done_after_abort", 32'(n_done - nd0), 32'd0);
    @(negedge clk);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, "after_reset");
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_sub_16bit.md
SERIAL_SUB_16BIT -- requirements
Module: serial_sub_16bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; it is sampled only in IDLE.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits: the minuend and subtrahend, captured on an accepted start.
REQ-006 The block SHALL have port bin, input, 1 bit: the borrow-in, captured on an accepted start.
REQ-007 The block SHALL have port diff, output, WIDTH bits: the result a - b - bin, modulo 2^WIDTH.
REQ-008 The block SHALL have port bout, output, 1 bit: the borrow-out, 1 when a < b + bin (unsigned).
REQ-009 The block SHALL have port busy, output, 1 bit: high while a subtraction is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse when diff and bout are valid.

Function
REQ-011 The FSM SHALL have exactly three states:
- IDLE
- RUN
- DONE
REQ-012 In IDLE with start=1, the block SHALL:
- capture a, b and bin into internal shift and borrow registers;
- clear the bit counter;
- enter RUN.
REQ-013 In IDLE with start=0, the block SHALL remain in IDLE with no change to any register.
REQ-014 Each RUN cycle SHALL process one bit, LSB first, with x = a bit, y = b bit and br = the borrow register:
- d = x ^ y ^ br;
- br_next = (~x & y) | (~(x ^ y) & br);
- d SHALL be shifted into the MSB of the result register.
REQ-015 The block SHALL remain in RUN for exactly WIDTH cycles, counted by a counter of width ceil(log2(WIDTH+1)).
REQ-016 After the last RUN cycle, the block SHALL enter DONE and drive:
- diff = the full result;
- bout = the final borrow;
- done = 1.
REQ-017 From DONE, the block SHALL go to IDLE unconditionally on the next cycle.
REQ-018 done SHALL be high for exactly one cycle per accepted start.
REQ-019 If start is sampled at edge N, done SHALL be high in the cycle after edge N+WIDTH+1 (WIDTH=16: 17 edges).
REQ-020 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-021 start SHALL be ignored in RUN and DONE, and a and b changes after capture SHALL NOT affect the result.
REQ-022 diff and bout SHALL hold their last completed values until the next DONE.
REQ-023 diff and bout SHALL NOT change during RUN.
REQ-024 A start in the IDLE cycle directly after DONE SHALL be accepted (back-to-back operation).

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously set:
- state to IDLE;
- the counter and all data and borrow registers to 0;
- diff=0, bout=0, busy=0, done=0.
REQ-026 Reset asserted mid-operation SHALL abort the operation, produce no done pulse, and return the block to IDLE.
REQ-027 After rst_n deasserts, the first rising edge SHALL be able to accept a start.

Structure
REQ-028 A shared package SHALL hold:
- the state enumeration (IDLE, RUN, DONE);
- the default WIDTH constant (16).
REQ-029 The one-bit full subtractor (inputs x, y, bin; outputs d, bout) SHALL be a separate combinational sub-module named full_subtractor, instantiated once.
REQ-030 The block SHALL contain no combinational path from start, a, b or bin to any output.

Verification
REQ-031 Basic subtraction: a=0x1234, b=0x0234, bin=0, start pulse -> diff=0x1000, bout=0, with done 17 edges after the start edge.
REQ-032 Underflow: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1.
REQ-033 Borrow-in and borrow chain: a=0xFFFF, b=0xFFFF, bin=1 -> diff=0xFFFF, bout=1.
REQ-034 Start while busy is ignored, and back-to-back works:
- a=0x00FF, b=0x000F starts, then start=1 with a=0, b=0 held through RUN;
- required: a single done with diff=0x00F0;
- then start immediately after DONE with a=5, b=3 -> diff=0x0002, bout=0.
REQ-035 Reset mid-operation: rst_n pulsed low at RUN cycle 8 -> busy=0, diff=0, no done pulse, and the next operation 0x8000-0x0001 -> diff=0x7FFF, bout=0.
